ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Upstream input stage of the Bulls-and-Cows game.
- Receives PS/2 keyboard frames on PS2_CLK/PS2_DATA and validates start, parity and stop bits.
- Tracks make, break and extended prefixes and suppresses typematic repeats.
- Emits one-cycle key events (digits 0-9, Enter, Backspace, Esc) to the game FSM, plus raw scan codes for LED debug.

Parameters:
- FILTER_LEN, 8: consecutive equal samples of synchronized PS2_CLK needed before the filtered clock changes.
- TIMEOUT_CYCLES, 10000: max iCLK_50 cycles between falling edges inside a frame (200 us at 50 MHz).

Ports:
- iCLK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- PS2_CLK  in  1  raw keyboard clock, asynchronous.
- PS2_DATA  in  1  raw keyboard data, asynchronous.
- oSCAN_VALID  out  1  one-cycle pulse: a good frame was received.
- oSCAN_CODE  out  8  last good scan byte; holds until the next good frame.
- oKEY_VALID  out  1  one-cycle pulse: a new key press.
- oKEY_CODE  out  4  0-9 digit, 10 Enter, 11 Backspace, 12 Esc; holds between events.
- oPARITY_ERR  out  1  one-cycle pulse: parity or stop-bit error.
- oFRAME_ERR  out  1  one-cycle pulse: inter-bit timeout.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - FSM in IDLE; shift register and bit counter 0.
  - break_pending, ext_pending and held_valid cleared.
  - Synchronizers and filter preset to 1 (idle bus).
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through a 2-flop synchronizer.
  - Filtered clock toggles only after FILTER_LEN consecutive samples differ from its current value.
  - A falling edge of the filtered clock is a "bit strobe"; data is sampled from synchronized PS2_DATA on that cycle.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on strobe with data=0 (start bit) go to DATA with bit count 0. On strobe with data=1, stay in IDLE with no error.
  - DATA: shift LSB first, 8 strobes, then go to PARITY.
  - PARITY: capture the bit. Odd parity is required: the XOR of 8 data bits and the parity bit must be 1.
  - STOP: strobe with data=1 and parity good -> good frame. Otherwise pulse oPARITY_ERR and discard the byte. Return to IDLE either way.
  - Timeout: counter clears on every strobe and counts while not in IDLE. Reaching TIMEOUT_CYCLES pulses oFRAME_ERR, returns to IDLE and clears break_pending and ext_pending.
- Good frame:
  - oSCAN_CODE is updated and oSCAN_VALID pulses on the cycle after the stop-bit strobe.
  - The decoder processes the byte in the same cycle as that pulse.
  - Any error (parity or frame) also clears break_pending and ext_pending.
- Decoder, registered; oKEY_VALID/oKEY_CODE appear 1 cycle after oSCAN_VALID:
  - 0xE0: set ext_pending; no event.
  - 0xF0: set break_pending; no event.
  - Other byte with break_pending: if it equals held_code, clear held_valid. Clear both pending flags; no event.
  - Other byte as a make: map to a key; clear both pending flags.
  - Main-row digit map: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
  - Keypad digit map (non-extended only): 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
  - 5A (with or without E0) = 10. 66 = 11. 76 = 12.
  - Any other byte, or an extended keypad code: no event.
- Repeat suppression:
  - A mapped make whose {ext, byte} equals the held key with held_valid=1 produces no event.
  - Otherwise pulse oKEY_VALID, update oKEY_CODE, store the held key and set held_valid.
  - A different key pressed while another is held replaces the held key and generates an event.

Decomposition:
- Package bc_pkg holds:
  - KEY_ENTER=10, KEY_BKSP=11, KEY_ESC=12.
  - SC_BREAK=8'hF0, SC_EXT=8'hE0.
  - The frame FSM state enum.
- Sub-module ps2_frame_rx owns the synchronizers, filter, frame FSM and timeout. Its outputs are byte, valid, parity_err and frame_err.
- ps2_key_decoder instantiates ps2_frame_rx and adds the prefix, map and repeat logic.

Test Plan:
- Send frame 0x16 (odd parity 0, stop 1) at a 80 us bit period -> oSCAN_VALID once with code 0x16; next cycle oKEY_VALID once with code 1.
- Send 0x16 three times, then F0 16, then 16 -> exactly 2 oKEY_VALID events (code 1); no key event for the break.
- Send E0 5A -> key code 10. Send E0 70 -> no key event. Send 70 -> key code 0.
- Send 0x45 with a wrong parity bit -> oPARITY_ERR pulse; no oSCAN_VALID or oKEY_VALID. A following good 0x45 -> key code 0.
- Stop clocking after 4 data bits -> oFRAME_ERR about 10000 cycles after the last strobe. A following full frame 0x66 -> key code 11.
- Assert reset mid-frame (after 5 bits) and release -> all outputs 0. A following frame 0x76 decodes to 12 with no stale bits.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared constants, frame FSM state type and scan-code-to-key mapping for the
// Bulls-and-Cows keyboard front end.
package bc_pkg;

   localparam logic [3:0] KEY_ENTER = 4'd10;
   localparam logic [3:0] KEY_BKSP  = 4'd11;
   localparam logic [3:0] KEY_ESC   = 4'd12;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } frame_state_t;

   typedef struct packed {
      logic       hit;
      logic [3:0] code;
   } key_map_t;

   // Keypad digits share codes with extended navigation keys, so they only
   // count as digits when no E0 prefix preceded them.
   function automatic key_map_t mapScanCode(input logic i_ext, input logic [7:0] i_code);
      key_map_t m;
      m.hit  = 1'b1;
      m.code = 4'd0;
      case (i_code)
         8'h45: m.code = 4'd0;
         8'h16: m.code = 4'd1;
         8'h1E: m.code = 4'd2;
         8'h26: m.code = 4'd3;
         8'h25: m.code = 4'd4;
         8'h2E: m.code = 4'd5;
         8'h36: m.code = 4'd6;
         8'h3D: m.code = 4'd7;
         8'h3E: m.code = 4'd8;
         8'h46: m.code = 4'd9;
         8'h70: begin m.code = 4'd0; m.hit = ~i_ext; end
         8'h69: begin m.code = 4'd1; m.hit = ~i_ext; end
         8'h72: begin m.code = 4'd2; m.hit = ~i_ext; end
         8'h7A: begin m.code = 4'd3; m.hit = ~i_ext; end
         8'h6B: begin m.code = 4'd4; m.hit = ~i_ext; end
         8'h73: begin m.code = 4'd5; m.hit = ~i_ext; end
         8'h74: begin m.code = 4'd6; m.hit = ~i_ext; end
         8'h6C: begin m.code = 4'd7; m.hit = ~i_ext; end
         8'h75: begin m.code = 4'd8; m.hit = ~i_ext; end
         8'h7D: begin m.code = 4'd9; m.hit = ~i_ext; end
         8'h5A: m.code = KEY_ENTER;
         8'h66: m.code = KEY_BKSP;
         8'h76: m.code = KEY_ESC;
         default: m.hit = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, clock glitch filter, 11-bit frame
// FSM with odd-parity/stop validation and an inter-bit timeout.
module ps2_frame_rx
   import bc_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       i_clk,
   input  logic       i_rstN,
   input  logic       i_ps2Clk,
   input  logic       i_ps2Data,
   output logic [7:0] o_byte,
   output logic       o_valid,
   output logic       o_parityErr,
   output logic       o_frameErr
);

   localparam int FW = $clog2(FILTER_LEN) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    r_clkSync;
   logic [1:0]    r_dataSync;
   logic          r_filtClk;
   logic          r_filtPrev;
   logic [FW-1:0] r_filtCnt;

   frame_state_t  r_state;
   logic [7:0]    r_shift;
   logic [2:0]    r_bitCnt;
   logic          r_parity;
   logic [TW-1:0] r_toCnt;

   logic          w_strobe;
   logic          w_bit;
   logic          w_timeout;

   // Everything presets high so an idle bus never looks like a falling edge.
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_clkSync  <= 2'b11;
         r_dataSync <= 2'b11;
         r_filtClk  <= 1'b1;
         r_filtPrev <= 1'b1;
         r_filtCnt  <= '0;
      end else begin
         r_clkSync  <= {r_clkSync[0], i_ps2Clk};
         r_dataSync <= {r_dataSync[0], i_ps2Data};
         r_filtPrev <= r_filtClk;
         if (r_clkSync[1] != r_filtClk) begin
            if (r_filtCnt == FW'(FILTER_LEN - 1)) begin
               r_filtClk <= r_clkSync[1];
               r_filtCnt <= '0;
            end else begin
               r_filtCnt <= r_filtCnt + 1'b1;
            end
         end else begin
            r_filtCnt <= '0;
         end
      end
   end

   assign w_strobe  = r_filtPrev & ~r_filtClk;
   assign w_bit     = r_dataSync[1];
   assign w_timeout = (r_state != ST_IDLE) && !w_strobe && (r_toCnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_bitCnt    <= '0;
         r_parity    <= 1'b0;
         r_toCnt     <= '0;
         o_byte      <= '0;
         o_valid     <= 1'b0;
         o_parityErr <= 1'b0;
         o_frameErr  <= 1'b0;
      end else begin
         o_valid     <= 1'b0;
         o_parityErr <= 1'b0;
         o_frameErr  <= 1'b0;

         if (r_state == ST_IDLE || w_strobe || w_timeout) begin
            r_toCnt <= '0;
         end else begin
            r_toCnt <= r_toCnt + 1'b1;
         end

         if (w_timeout) begin
            o_frameErr <= 1'b1;
            r_state    <= ST_IDLE;
            r_bitCnt   <= '0;
         end else if (w_strobe) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_bit) begin
                     r_state  <= ST_DATA;
                     r_bitCnt <= '0;
                     r_shift  <= '0;
                  end
               end
               ST_DATA: begin
                  r_shift <= {w_bit, r_shift[7:1]};
                  if (r_bitCnt == 3'd7) begin
                     r_state <= ST_PARITY;
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                  end
               end
               ST_PARITY: begin
                  r_parity <= w_bit;
                  r_state  <= ST_STOP;
               end
               ST_STOP: begin
                  if (w_bit && ((^r_shift) ^ r_parity)) begin
                     o_byte  <= r_shift;
                     o_valid <= 1'b1;
                  end else begin
                     o_parityErr <= 1'b1;
                  end
                  r_state  <= ST_IDLE;
                  r_bitCnt <= '0;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end for the Bulls-and-Cows game: turns validated scan
// bytes into one-cycle key events, handling E0/F0 prefixes and typematic repeat.
module ps2_key_decoder
   import bc_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       iCLK_50,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic       oSCAN_VALID,
   output logic [7:0] oSCAN_CODE,
   output logic       oKEY_VALID,
   output logic [3:0] oKEY_CODE,
   output logic       oPARITY_ERR,
   output logic       oFRAME_ERR
);

   logic [7:0] w_rxByte;
   logic       w_rxValid;
   logic       w_rxParityErr;
   logic       w_rxFrameErr;
   key_map_t   w_map;
   logic [8:0] w_fullCode;

   logic       r_breakPending;
   logic       r_extPending;
   logic       r_heldValid;
   logic [8:0] r_heldCode;
   logic       r_keyValid;
   logic [3:0] r_keyCode;

   ps2_frame_rx #(
      .FILTER_LEN     (FILTER_LEN),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_frameRx (
      .i_clk       (iCLK_50),
      .i_rstN      (reset),
      .i_ps2Clk    (PS2_CLK),
      .i_ps2Data   (PS2_DATA),
      .o_byte      (w_rxByte),
      .o_valid     (w_rxValid),
      .o_parityErr (w_rxParityErr),
      .o_frameErr  (w_rxFrameErr)
   );

   assign w_map      = mapScanCode(r_extPending, w_rxByte);
   assign w_fullCode = {r_extPending, w_rxByte};

   // Held key is tracked as {ext, byte} so E0-prefixed and plain keys that
   // share a byte never suppress or release each other.
   always_ff @(posedge iCLK_50 or negedge reset) begin
      if (!reset) begin
         r_breakPending <= 1'b0;
         r_extPending   <= 1'b0;
         r_heldValid    <= 1'b0;
         r_heldCode     <= '0;
         r_keyValid     <= 1'b0;
         r_keyCode      <= '0;
      end else begin
         r_keyValid <= 1'b0;
         if (w_rxParityErr || w_rxFrameErr) begin
            r_breakPending <= 1'b0;
            r_extPending   <= 1'b0;
         end else if (w_rxValid) begin
            if (w_rxByte == SC_EXT) begin
               r_extPending <= 1'b1;
            end else if (w_rxByte == SC_BREAK) begin
               r_breakPending <= 1'b1;
            end else begin
               r_breakPending <= 1'b0;
               r_extPending   <= 1'b0;
               if (r_breakPending) begin
                  if (w_fullCode == r_heldCode) begin
                     r_heldValid <= 1'b0;
                  end
               end else if (w_map.hit && !(r_heldValid && (w_fullCode == r_heldCode))) begin
                  r_keyValid  <= 1'b1;
                  r_keyCode   <= w_map.code;
                  r_heldCode  <= w_fullCode;
                  r_heldValid <= 1'b1;
               end
            end
         end
      end
   end

   assign oSCAN_VALID = w_rxValid;
   assign oSCAN_CODE  = w_rxByte;
   assign oKEY_VALID  = r_keyValid;
   assign oKEY_CODE   = r_keyCode;
   assign oPARITY_ERR = w_rxParityErr;
   assign oFRAME_ERR  = w_rxFrameErr;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: table-driven frames with a scan/key
// scoreboard, plus hand-written timeout and mid-frame reset sequences.
module tb_ps2_key_decoder;

   localparam int TIMEOUT = 300;
   localparam int HALF    = 20;

   typedef struct {
      logic [7:0] code;
      bit         bad;
      int         key;
   } vec_t;

   logic       iCLK_50 = 1'b0;
   logic       reset   = 1'b0;
   logic       ps2Clk  = 1'b1;
   logic       ps2Data = 1'b1;
   logic       oSCAN_VALID;
   logic [7:0] oSCAN_CODE;
   logic       oKEY_VALID;
   logic [3:0] oKEY_CODE;
   logic       oPARITY_ERR;
   logic       oFRAME_ERR;

   logic [7:0] scanQ[$];
   logic [3:0] keyQ[$];
   vec_t       vecs[$];
   int         checks     = 0;
   int         errors     = 0;
   int         expParity  = 0;
   int         seenParity = 0;
   int         expFrame   = 0;
   int         seenFrame  = 0;
   int         cycleCount = 0;
   bit         prevScan   = 1'b0;

   ps2_key_decoder #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .iCLK_50     (iCLK_50),
      .reset       (reset),
      .PS2_CLK     (ps2Clk),
      .PS2_DATA    (ps2Data),
      .oSCAN_VALID (oSCAN_VALID),
      .oSCAN_CODE  (oSCAN_CODE),
      .oKEY_VALID  (oKEY_VALID),
      .oKEY_CODE   (oKEY_CODE),
      .oPARITY_ERR (oPARITY_ERR),
      .oFRAME_ERR  (oFRAME_ERR)
   );

   always #10 iCLK_50 = ~iCLK_50;

   always @(posedge iCLK_50) cycleCount++;

   task automatic checkEq(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Scoreboard side: pops expectations whenever the DUT pulses an event.
   always @(negedge iCLK_50) begin
      logic [7:0] expScan;
      logic [3:0] expKey;
      if (reset) begin
         if (oSCAN_VALID) begin
            if (scanQ.size() == 0) begin
               checkEq("unexpected scan event", {24'd0, oSCAN_CODE}, 32'hFFFF_FFFF);
            end else begin
               expScan = scanQ.pop_front();
               checkEq("scan code", {24'd0, oSCAN_CODE}, {24'd0, expScan});
            end
         end
         if (oKEY_VALID) begin
            checkEq("key one cycle after scan", {31'd0, prevScan}, 32'd1);
            if (keyQ.size() == 0) begin
               checkEq("unexpected key event", {28'd0, oKEY_CODE}, 32'hFFFF_FFFF);
            end else begin
               expKey = keyQ.pop_front();
               checkEq("key code", {28'd0, oKEY_CODE}, {28'd0, expKey});
            end
         end
         if (oPARITY_ERR) seenParity++;
         if (oFRAME_ERR) seenFrame++;
         prevScan = oSCAN_VALID;
      end else begin
         prevScan = 1'b0;
      end
   end

   task automatic ps2Bit(input logic b);
      ps2Data = b;
      repeat (HALF) @(negedge iCLK_50);
      ps2Clk = 1'b0;
      repeat (HALF) @(negedge iCLK_50);
      ps2Clk = 1'b1;
   endtask

   task automatic sendFrame(input logic [7:0] code, input bit bad);
      logic p;
      p = (~^code) ^ bad;
      ps2Bit(1'b0);
      for (int i = 0; i < 8; i++) ps2Bit(code[i]);
      ps2Bit(p);
      ps2Bit(1'b1);
      repeat (60) @(negedge iCLK_50);
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.bad) begin
         expParity++;
      end else begin
         scanQ.push_back(v.code);
         if (v.key >= 0) keyQ.push_back(4'(v.key));
      end
      sendFrame(v.code, v.bad);
   endtask

   task automatic checkOutput(input string tag);
      checkEq({tag, " scan events drained"}, scanQ.size(), 0);
      checkEq({tag, " key events drained"}, keyQ.size(), 0);
      checkEq({tag, " parity error count"}, seenParity, expParity);
      checkEq({tag, " frame error count"}, seenFrame, expFrame);
   endtask

   task automatic checkAllZero(input string tag);
      checkEq({tag, " oSCAN_VALID"}, {31'd0, oSCAN_VALID}, 32'd0);
      checkEq({tag, " oSCAN_CODE"}, {24'd0, oSCAN_CODE}, 32'd0);
      checkEq({tag, " oKEY_VALID"}, {31'd0, oKEY_VALID}, 32'd0);
      checkEq({tag, " oKEY_CODE"}, {28'd0, oKEY_CODE}, 32'd0);
      checkEq({tag, " oPARITY_ERR"}, {31'd0, oPARITY_ERR}, 32'd0);
      checkEq({tag, " oFRAME_ERR"}, {31'd0, oFRAME_ERR}, 32'd0);
   endtask

   initial begin
      repeat (90000) @(posedge iCLK_50);
      $display("[TB] FAIL watchdog: got no finish after 90000 cycles, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit found;
      int t0;
      int delay;

      vecs.push_back('{8'h16, 1'b0, 1});
      vecs.push_back('{8'h16, 1'b0, -1});
      vecs.push_back('{8'h16, 1'b0, -1});
      vecs.push_back('{8'hF0, 1'b0, -1});
      vecs.push_back('{8'h16, 1'b0, -1});
      vecs.push_back('{8'h16, 1'b0, 1});
      vecs.push_back('{8'hE0, 1'b0, -1});
      vecs.push_back('{8'h5A, 1'b0, 10});
      vecs.push_back('{8'hE0, 1'b0, -1});
      vecs.push_back('{8'h70, 1'b0, -1});
      vecs.push_back('{8'h70, 1'b0, 0});
      vecs.push_back('{8'hF0, 1'b0, -1});
      vecs.push_back('{8'h45, 1'b1, -1});
      vecs.push_back('{8'h45, 1'b0, 0});
      vecs.push_back('{8'h1E, 1'b0, 2});
      vecs.push_back('{8'h26, 1'b0, 3});
      vecs.push_back('{8'h25, 1'b0, 4});
      vecs.push_back('{8'h2E, 1'b0, 5});
      vecs.push_back('{8'h36, 1'b0, 6});
      vecs.push_back('{8'h3D, 1'b0, 7});
      vecs.push_back('{8'h3E, 1'b0, 8});
      vecs.push_back('{8'h46, 1'b0, 9});
      vecs.push_back('{8'h69, 1'b0, 1});
      vecs.push_back('{8'h72, 1'b0, 2});
      vecs.push_back('{8'h1C, 1'b0, -1});
      vecs.push_back('{8'hE0, 1'b0, -1});
      vecs.push_back('{8'hF0, 1'b0, -1});
      vecs.push_back('{8'h72, 1'b0, -1});
      vecs.push_back('{8'h72, 1'b0, -1});
      vecs.push_back('{8'h7D, 1'b0, 9});
      vecs.push_back('{8'h5A, 1'b0, 10});

      repeat (5) @(negedge iCLK_50);
      checkAllZero("reset");
      reset = 1'b1;
      repeat (20) @(negedge iCLK_50);

      foreach (vecs[i]) applyStimulus(vecs[i]);
      checkOutput("table");

      // Pending E0 must be dropped by the timeout, so the following 70 is keypad 0.
      applyStimulus('{8'hE0, 1'b0, -1});
      ps2Bit(1'b0);
      ps2Bit(1'b1);
      ps2Bit(1'b0);
      ps2Bit(1'b1);
      ps2Bit(1'b1);
      t0 = cycleCount - HALF;
      expFrame++;
      found = 1'b0;
      for (int i = 0; i < TIMEOUT * 3 && !found; i++) begin
         @(negedge iCLK_50);
         if (oFRAME_ERR) found = 1'b1;
      end
      delay = cycleCount - t0;
      checkEq("frame error seen", {31'd0, found}, 32'd1);
      checks++;
      if (!found || delay < TIMEOUT || delay > TIMEOUT + 30) begin
         errors++;
         $display("[TB] FAIL frame error latency: got %0d cycles, expected %0d..%0d", delay, TIMEOUT, TIMEOUT + 30);
      end
      repeat (20) @(negedge iCLK_50);
      applyStimulus('{8'h70, 1'b0, 0});
      applyStimulus('{8'h66, 1'b0, 11});
      checkOutput("timeout");

      ps2Bit(1'b0);
      ps2Bit(1'b1);
      ps2Bit(1'b1);
      ps2Bit(1'b0);
      ps2Bit(1'b1);
      reset = 1'b0;
      #1;
      checkAllZero("mid-frame reset");
      repeat (5) @(negedge iCLK_50);
      reset = 1'b1;
      repeat (20) @(negedge iCLK_50);
      applyStimulus('{8'h76, 1'b0, 12});
      checkOutput("after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
